add_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares the single 16-bit ripple adder among up to NREQ requesters, such as PC increment, branch-target and load/store address generation. Each requester presents operands with a request. The block grants one requester at a time, latches its operands and registers the sum. It then returns the sum with a one-cycle acknowledge to the winner. Operands are registered in front of the adder so its ripple path runs from a flop to a flop.

---
 rtl/add_share_arb_pkg.sv | 46 ++++
 rtl/add_share_arb_add16.sv | 27 ++
 rtl/add_share_arb.sv | 114 +++++++++++
 tb/tb_add_share_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : add_share_arb_pkg
// Brief   : Shared types, widths and the round-robin pick helper for add_share_arb
// Revision: 1.0
// ============================================================================
package add_share_arb_pkg;

    localparam int ADD_W        = 16;
    localparam int DEFAULT_NREQ = 3;
    localparam int RR_IDX_W     = 3;   // enough for up to 8 requesters

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // First set bit of req at or above ptr, wrapping at nreq; 0 if none set.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [7:0]          req,
        input logic [RR_IDX_W-1:0] ptr,
        input int unsigned         nreq
    );
        logic [RR_IDX_W-1:0] win;
        logic                found;
        int unsigned         idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nreq) begin
                idx = {29'd0, ptr} + i;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (!found && req[idx[RR_IDX_W-1:0]]) begin
                    win   = idx[RR_IDX_W-1:0];
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_share_arb_add16.sv
`default_nettype none
// ============================================================================
// Module  : add_16bit
// Brief   : 16-bit ripple-carry adder, carry-in tied low, carry-out discarded
// Revision: 1.0
// ============================================================================
module add_16bit
    import add_share_arb_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    output logic [ADD_W-1:0] s
);

    logic [ADD_W-1:0] w_c;

    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < ADD_W; i++) begin : g_bit
        assign s[i] = a[i] ^ b[i] ^ w_c[i];
        if (i < ADD_W - 1) begin : g_carry
            assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

endmodule
`default_nettype wire

// File: rtl/add_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : add_share_arb
// Brief   : Round-robin arbiter sharing one registered 16-bit adder among NREQ requesters
// Revision: 1.0
// ============================================================================
module add_share_arb
    import add_share_arb_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int W    = ADD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      sum,
    output logic              ovf,
    output logic              busy
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [RR_IDX_W-1:0]  r_ptr;
    logic [RR_IDX_W-1:0]  r_owner;
    logic [W-1:0]         r_op_a;
    logic [W-1:0]         r_op_b;
    logic [W-1:0]         r_sum;
    logic                 r_ovf;
    logic [NREQ-1:0]      r_ack;
    logic                 r_busy;

    logic [W-1:0]         w_add;
    logic [RR_IDX_W-1:0]  w_grant;
    logic                 w_latch;
    logic                 w_capture;
    logic                 w_release;
    logic [NREQ-1:0]      w_ack_d;
    logic                 w_busy_d;

    add_16bit u_add (
        .a (r_op_a),
        .b (r_op_b),
        .s (w_add)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|req) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ack and busy are computed one cycle early so they leave the block from flops.
    always_comb begin
        w_grant   = rr_pick(8'(req), r_ptr, NREQ);
        w_latch   = (r_state == IDLE) && (|req);
        w_capture = (r_state == EXEC);
        w_release = (r_state == RESP);
        w_ack_d   = '0;
        if (w_capture) begin
            w_ack_d = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
        end
        w_busy_d  = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_ack  <= w_ack_d;
            r_busy <= w_busy_d;
            if (w_latch) begin
                r_op_a  <= a_in[w_grant*W +: W];
                r_op_b  <= b_in[w_grant*W +: W];
                r_owner <= w_grant;
            end
            if (w_capture) begin
                r_sum <= w_add;
                r_ovf <= (r_op_a[W-1] == r_op_b[W-1]) && (w_add[W-1] != r_op_a[W-1]);
            end
            if (w_release) begin
                r_ptr <= (r_owner == RR_IDX_W'(NREQ-1)) ? '0 : r_owner + 1'b1;
            end
        end
    end

    assign ack  = r_ack;
    assign sum  = r_sum;
    assign ovf  = r_ovf;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_add_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_add_share_arb
// Brief   : Directed self-checking bench for add_share_arb (NREQ=3)
// Revision: 1.0
// ============================================================================
module tb_add_share_arb;

    localparam int NREQ = 3;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      sum;
    logic              ovf;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    add_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .a_in (a_in),
        .b_in (b_in),
        .ack  (ack),
        .sum  (sum),
        .ovf  (ovf),
        .busy (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_ops(input int idx, input logic [15:0] a, input logic [15:0] b);
        a_in[idx*W +: W] = a;
        b_in[idx*W +: W] = b;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (ack !== 3'b000 || sum !== 16'h0000 || ovf !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ack=%b sum=%h ovf=%b busy=%b, expected 000 0000 0 0", ack, sum, ovf, busy);
        end
        @(negedge clk);
        n_checks++;
        if (ack !== 3'b000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: ack=%b busy=%b, expected 000 0", ack, busy);
        end
    endtask

    task automatic test_single(input string tag, input int idx, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] exp_s, input logic exp_o);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        @(negedge clk);
        set_ops(idx, a, b);
        req = oh;
        @(negedge clk);
        n_checks++;
        if (ack !== 3'b000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_exec: ack=%b busy=%b, expected 000 1", tag, ack, busy);
        end
        set_ops(idx, ~a, ~b);
        @(negedge clk);
        n_checks++;
        if (ack !== oh || sum !== exp_s || ovf !== exp_o) begin
            n_fail++;
            $display("FAIL %s_resp: ack=%b sum=%h ovf=%b, expected %b %h %b", tag, ack, sum, ovf, oh, exp_s, exp_o);
        end
        @(negedge clk);
        req = '0;
        n_checks++;
        if (ack !== 3'b000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: ack=%b busy=%b, expected 000 0", tag, ack, busy);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (sum !== exp_s || ovf !== exp_o || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_hold: sum=%h ovf=%b busy=%b, expected %h %b 0", tag, sum, ovf, busy, exp_s, exp_o);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_seq [6];
        logic [15:0]     exp_sum [3];
        int              phase   [3];
        int              seen;
        int              last_cyc;
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_sum = '{16'h0003, 16'h0030, 16'h0300};
        phase   = '{0, 0, 0};
        seen     = 0;
        last_cyc = 0;
        do_reset();
        set_ops(0, 16'h0001, 16'h0002);
        set_ops(1, 16'h0010, 16'h0020);
        set_ops(2, 16'h0100, 16'h0200);
        req = 3'b111;
        for (int cyc = 0; cyc < 40 && seen < 6; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (phase[i] == 2) begin
                    req[i]   = 1'b1;
                    phase[i] = 0;
                end else if (phase[i] == 1) begin
                    req[i]   = 1'b0;
                    phase[i] = 2;
                end
            end
            if (ack !== 3'b000) begin
                n_checks++;
                if (ack !== exp_seq[seen]) begin
                    n_fail++;
                    $display("FAIL rr_order_%0d: ack=%b, expected %b", seen, ack, exp_seq[seen]);
                end
                n_checks++;
                if (sum !== exp_sum[seen % 3]) begin
                    n_fail++;
                    $display("FAIL rr_sum_%0d: sum=%h, expected %h", seen, sum, exp_sum[seen % 3]);
                end
                if (seen > 0) begin
                    n_checks++;
                    if (cyc - last_cyc != 3) begin
                        n_fail++;
                        $display("FAIL rr_spacing_%0d: gap=%0d, expected 3", seen, cyc - last_cyc);
                    end
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (ack[i] === 1'b1) phase[i] = 1;
                end
                last_cyc = cyc;
                seen++;
            end
        end
        req = '0;
        n_checks++;
        if (seen != 6) begin
            n_fail++;
            $display("FAIL rr_count: acks seen=%0d, expected 6", seen);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        // leaves ptr at 1 and a nonzero sum so the abort has something to clear
        test_single("pre", 0, 16'h1111, 16'h2222, 16'h3333, 1'b0);
        @(negedge clk);
        set_ops(2, 16'h0005, 16'h0006);
        req = 3'b100;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_exec: busy=%b, expected 1", busy);
        end
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        n_checks++;
        if (ack !== 3'b000 || busy !== 1'b0 || sum !== 16'h0000 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: ack=%b busy=%b sum=%h ovf=%b, expected 000 0 0000 0", ack, busy, sum, ovf);
        end
        rst = 1'b0;
        set_ops(0, 16'h0100, 16'h0001);
        set_ops(1, 16'h0002, 16'h0003);
        req = 3'b011;
        @(negedge clk);
        n_checks++;
        if (ack !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_no_ack: ack=%b, expected 000", ack);
        end
        @(negedge clk);
        n_checks++;
        if (ack !== 3'b001 || sum !== 16'h0101) begin
            n_fail++;
            $display("FAIL abort_first: ack=%b sum=%h, expected 001 0101", ack, sum);
        end
        @(negedge clk);
        req = 3'b010;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ack !== 3'b010 || sum !== 16'h0005) begin
            n_fail++;
            $display("FAIL abort_second: ack=%b sum=%h, expected 010 0005", ack, sum);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ack !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_drain: busy=%b ack=%b, expected 0 000", busy, ack);
        end
    endtask

    task automatic test_drop_in_exec();
        @(negedge clk);
        set_ops(1, 16'h4000, 16'h4000);
        req = 3'b010;
        @(negedge clk);
        req = 3'b000;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_exec: busy=%b, expected 1", busy);
        end
        @(negedge clk);
        n_checks++;
        if (ack !== 3'b010 || sum !== 16'h8000 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_resp: ack=%b sum=%h ovf=%b, expected 010 8000 1", ack, sum, ovf);
        end
        @(negedge clk);
        n_checks++;
        if (ack !== 3'b000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle: ack=%b busy=%b, expected 000 0", ack, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ack !== 3'b000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_no_extra: ack=%b busy=%b, expected 000 0", ack, busy);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        test_reset();
        test_single("pos_ovf",  0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
        test_single("wrap",     0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        test_single("plain",    1, 16'h1234, 16'h1111, 16'h2345, 1'b0);
        test_single("neg_ovf",  2, 16'h8000, 16'h8000, 16'h0000, 1'b1);
        test_single("neg_ok",   2, 16'hFFFE, 16'hFFFD, 16'hFFFB, 1'b0);
        test_round_robin();
        test_reset_mid_op();
        test_drop_in_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
